// File: rtl/led_pattern_gen_if.sv
// Pattern-select inputs and LED bank output of led_pattern_gen, bundled for the board top.
// master drives MODE/PAUSE and observes LEDG; slave is the pattern engine.
interface led_pattern_gen_if #(
   parameter int unsigned LED_W = 8
);
   logic [1:0]       MODE;
   logic             PAUSE;
   logic [LED_W-1:0] LEDG;

   modport master (output MODE, output PAUSE, input LEDG);
   modport slave  (input MODE, input PAUSE, output LEDG);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaler ticks step a pattern in legacy, rotate, bounce or count mode.
// Define LED_PATTERN_BOUNCE_EN to build the bounce mode; otherwise mode 2 is a second rotate.
module led_pattern_gen #(
   parameter int unsigned LED_W    = 8,
   parameter int unsigned CNT_W    = 28,
   parameter int unsigned SLOW_BIT = 25,
   parameter int unsigned FAST_BIT = 23
) (
   input logic              CLOCK_50,
   input logic              RESET_N,
   led_pattern_gen_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_LEGACY = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       fast_dly_q, fast_dly_d;
   logic [2:0]       slow_dly_q, slow_dly_d;
   logic [1:0]       mode_s1_q, mode_s1_d;
   logic [1:0]       mode_s2_q, mode_s2_d;
   logic             pause_s1_q, pause_s1_d;
   logic             pause_s2_q, pause_s2_d;
   mode_e            mode_q, mode_d;
   logic [LED_W-1:0] ledg_q, ledg_d;
   logic             fast_tick_c;
   logic             slow_tick_c;
   logic [LED_W-1:0] rot_c;

`ifdef LED_PATTERN_BOUNCE_EN
   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   dir_e dir_q, dir_d;
   logic onehot_c;

   assign onehot_c = (ledg_q != '0) && ((ledg_q & (ledg_q - LED_W'(1))) == '0);
`endif

   // One-cycle tick per rising edge of each tapped prescaler bit.
   assign fast_tick_c = !fast_dly_q[2] && fast_dly_q[1];
   assign slow_tick_c = !slow_dly_q[2] && slow_dly_q[1];

   // An empty pattern re-seeds instead of rotating zeros forever.
   assign rot_c = (ledg_q == '0) ? LED_W'(1) : {ledg_q[LED_W-2:0], ledg_q[LED_W-1]};

   assign bus.LEDG = ledg_q;

   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      fast_dly_d = {fast_dly_q[1:0], cnt_q[FAST_BIT]};
      slow_dly_d = {slow_dly_q[1:0], cnt_q[SLOW_BIT]};
      mode_s1_d  = bus.MODE;
      mode_s2_d  = mode_s1_q;
      pause_s1_d = bus.PAUSE;
      pause_s2_d = pause_s1_q;
      mode_d     = mode_q;
      ledg_d     = ledg_q;
`ifdef LED_PATTERN_BOUNCE_EN
      dir_d      = dir_q;
`endif

      // A mode change wins over ticks and pause, and loads the mode's seed.
      if (mode_s2_q != mode_q) begin
         mode_d = mode_e'(mode_s2_q);
         ledg_d = ((mode_s2_q == MODE_ROTATE) || (mode_s2_q == MODE_BOUNCE)) ? LED_W'(1) : '0;
`ifdef LED_PATTERN_BOUNCE_EN
         dir_d  = DIR_LEFT;
`endif
      end else if (!pause_s2_q) begin
         case (mode_q)
            MODE_LEGACY: begin
               if (fast_tick_c) ledg_d[LED_W-1:1] = ledg_q[LED_W-2:0];
               if (slow_tick_c) ledg_d[0] = ~ledg_q[0];
            end
`ifdef LED_PATTERN_BOUNCE_EN
            MODE_ROTATE: begin
               if (fast_tick_c) ledg_d = rot_c;
            end
            MODE_BOUNCE: begin
               if (fast_tick_c) begin
                  if (!onehot_c) begin
                     ledg_d = LED_W'(1);
                     dir_d  = DIR_LEFT;
                  end else if (dir_q == DIR_LEFT) begin
                     if (ledg_q[LED_W-1]) begin
                        dir_d  = DIR_RIGHT;
                        ledg_d = ledg_q >> 1;
                     end else begin
                        ledg_d = ledg_q << 1;
                     end
                  end else begin
                     if (ledg_q[0]) begin
                        dir_d  = DIR_LEFT;
                        ledg_d = ledg_q << 1;
                     end else begin
                        ledg_d = ledg_q >> 1;
                     end
                  end
               end
            end
`else
            MODE_ROTATE, MODE_BOUNCE: begin
               if (fast_tick_c) ledg_d = rot_c;
            end
`endif
            MODE_COUNT: begin
               if (slow_tick_c) ledg_d = ledg_q + LED_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q      <= '0;
         fast_dly_q <= '0;
         slow_dly_q <= '0;
         mode_s1_q  <= '0;
         mode_s2_q  <= '0;
         pause_s1_q <= 1'b0;
         pause_s2_q <= 1'b0;
         mode_q     <= MODE_LEGACY;
         ledg_q     <= '0;
`ifdef LED_PATTERN_BOUNCE_EN
         dir_q      <= DIR_LEFT;
`endif
      end else begin
         cnt_q      <= cnt_d;
         fast_dly_q <= fast_dly_d;
         slow_dly_q <= slow_dly_d;
         mode_s1_q  <= mode_s1_d;
         mode_s2_q  <= mode_s2_d;
         pause_s1_q <= pause_s1_d;
         pause_s2_q <= pause_s2_d;
         mode_q     <= mode_d;
         ledg_q     <= ledg_d;
`ifdef LED_PATTERN_BOUNCE_EN
         dir_q      <= dir_d;
`endif
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: every expected LEDG step is queued as (edge, value)
// and the monitor matches each observed LEDG change against the queue head.
module tb_led_pattern_gen;

   localparam int unsigned LED_W = 8;

   typedef struct {
      int unsigned at_edge;
      logic [7:0]  val;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   exp_t        exp_q[$];
   int unsigned edge_n = 0;
   logic [7:0]  prev   = 8'h00;
   int          errors = 0;
   int          checks = 0;

   led_pattern_gen_if #(.LED_W(LED_W)) bus ();

   led_pattern_gen #(
      .LED_W   (LED_W),
      .CNT_W   (8),
      .SLOW_BIT(5),
      .FAST_BIT(3)
   ) dut (
      .CLOCK_50(clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Monitor: count edges since reset release, compare every LEDG change with the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (!rst_n) edge_n = 0;
         else        edge_n = edge_n + 1;
         #1;
         if (!rst_n) begin
            prev = bus.LEDG;
         end else if (bus.LEDG !== prev) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_change: got %h at edge %0d, required no change", bus.LEDG, edge_n);
            end else begin
               e = exp_q.pop_front();
               if (bus.LEDG !== e.val || edge_n != e.at_edge) begin
                  errors = errors + 1;
                  $display("FAIL ledg_step: got %h at edge %0d, required %h at edge %0d",
                           bus.LEDG, edge_n, e.val, e.at_edge);
               end
            end
            prev = bus.LEDG;
         end
      end
   end

   task automatic push(input int unsigned at_edge, input logic [7:0] val);
      exp_t x;
      x.at_edge = at_edge;
      x.val     = val;
      exp_q.push_back(x);
   endtask

   task automatic wait_edge(input int unsigned n);
      while (edge_n < n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [1:0] mode);
      @(negedge clk);
      rst_n    = 1'b0;
      bus.MODE = mode;
      bus.PAUSE = 1'b0;
      #1;
      checks = checks + 1;
      if (bus.LEDG !== 8'h00) begin
         errors = errors + 1;
         $display("FAIL rst_async: got %h, required 00", bus.LEDG);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic end_scn(input string name);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL %s_pending: got %0d steps outstanding, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   initial begin
      bus.MODE  = 2'd0;
      bus.PAUSE = 1'b0;

      // Legacy toggle/shift from reset, then switch to mode 2 mid-run.
      do_reset(2'd0);
      push(35, 8'h01); push(43, 8'h03); push(59, 8'h07); push(75, 8'h0F);
      push(91, 8'h1F); push(99, 8'h1E);
      push(103, 8'h01); push(107, 8'h02); push(123, 8'h04); push(139, 8'h08);
      push(155, 8'h10); push(171, 8'h20); push(187, 8'h40); push(203, 8'h80);
`ifdef LED_PATTERN_BOUNCE_EN
      push(219, 8'h40); push(235, 8'h20);
`else
      push(219, 8'h01); push(235, 8'h02);
`endif
      wait_edge(100);
      bus.MODE = 2'd2;
      wait_edge(240);
      end_scn("legacy_bounce");

      // Rotate from reset including the 0x80 -> 0x01 wrap.
      do_reset(2'd1);
      push(3, 8'h01);
      for (int k = 0; k < 9; k++) begin
         logic [7:0] v;
         v = 8'h01 << ((k + 1) % 8);
         push(11 + 16 * k, v);
      end
      wait_edge(145);
      end_scn("rotate");

      // Pause across the fast ticks at edges 43 and 59; resume without catch-up.
      do_reset(2'd1);
      push(3, 8'h01); push(11, 8'h02); push(27, 8'h04); push(75, 8'h08); push(91, 8'h10);
      wait_edge(30);
      bus.PAUSE = 1'b1;
      wait_edge(60);
      bus.PAUSE = 1'b0;
      wait_edge(95);
      end_scn("pause");

      // Reset pulse while LEDG = 0x10, then reseed after release.
      do_reset(2'd1);
      push(3, 8'h01); push(11, 8'h02); push(27, 8'h04); push(43, 8'h08); push(59, 8'h10);
      wait_edge(62);
      end_scn("pre_reset");
      do_reset(2'd1);
      push(3, 8'h01); push(11, 8'h02);
      wait_edge(15);
      end_scn("post_reset");

      // Binary count across the full range and the wrap to zero.
      do_reset(2'd3);
      for (int v = 1; v < 256; v++) push(35 + 64 * (v - 1), 8'(v));
      push(35 + 64 * 255, 8'h00);
      wait_edge(16360);
      end_scn("count");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
